// File: rtl/regfile_idu.sv
`default_nettype none
// ============================================================================
// Module      : regfile_idu
// Description : GB-CPU register file (A,F,B,C,D,E,H,L,SP,PC) with a 16-bit
//               increment/decrement unit and a memory address mux.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_idu #(
    parameter int                    DATA_W    = 8,
    parameter logic [2*DATA_W-1:0]   PC_RESET  = '0,
    parameter logic [2*DATA_W-1:0]   SP_RESET  = 'hFFFE,
    parameter logic [DATA_W-1:0]     FLAG_MASK = 'hF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_sel,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  wr16_en,
    input  logic [1:0]            wr16_sel,
    input  logic [2*DATA_W-1:0]   data16_in,
    input  logic                  flags_wr_en,
    input  logic [DATA_W-1:0]     flags_in,
    input  logic [3:0]            flags_mask,
    input  logic [2:0]            rd_sel_a,
    input  logic [2:0]            rd_sel_b,
    output logic [DATA_W-1:0]     data_out_a,
    output logic [DATA_W-1:0]     data_out_b,
    input  logic                  idu_en,
    input  logic [2:0]            idu_sel,
    input  logic                  idu_dec,
    input  logic                  pc_load,
    input  logic [2*DATA_W-1:0]   pc_in,
    input  logic [2:0]            addr_sel,
    output logic [2*DATA_W-1:0]   addr_bus,
    output logic [DATA_W-1:0]     flags_out,
    output logic [2*DATA_W-1:0]   pc_out,
    output logic [2*DATA_W-1:0]   sp_out,
    output logic                  idu_wrap
);

    localparam int c_AW = 2 * DATA_W;

    localparam logic [2:0] c_SEL_B = 3'b000;
    localparam logic [2:0] c_SEL_C = 3'b001;
    localparam logic [2:0] c_SEL_D = 3'b010;
    localparam logic [2:0] c_SEL_E = 3'b011;
    localparam logic [2:0] c_SEL_H = 3'b100;
    localparam logic [2:0] c_SEL_L = 3'b101;
    localparam logic [2:0] c_SEL_F = 3'b110;
    localparam logic [2:0] c_SEL_A = 3'b111;

    localparam logic [1:0] c_P16_BC = 2'b00;
    localparam logic [1:0] c_P16_DE = 2'b01;
    localparam logic [1:0] c_P16_HL = 2'b10;
    localparam logic [1:0] c_P16_SP = 2'b11;

    localparam logic [2:0] c_T_PC = 3'b000;
    localparam logic [2:0] c_T_BC = 3'b001;
    localparam logic [2:0] c_T_DE = 3'b010;
    localparam logic [2:0] c_T_HL = 3'b011;
    localparam logic [2:0] c_T_SP = 3'b100;
    localparam logic [2:0] c_T_HC = 3'b101;
    localparam logic [2:0] c_T_PI = 3'b110;

    localparam logic [c_AW-1:0] c_ONE = {{(c_AW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_a, r_f, r_b, r_c, r_d, r_e, r_h, r_l;
    logic [c_AW-1:0]   r_pc, r_sp;
    logic              r_idu_wrap;

    logic [DATA_W-1:0] w_a_nx, w_f_nx, w_b_nx, w_c_nx, w_d_nx, w_e_nx, w_h_nx, w_l_nx;
    logic [c_AW-1:0]   w_pc_nx, w_sp_nx;

    logic [c_AW-1:0]   w_idu_old;
    logic [c_AW-1:0]   w_idu_res;
    logic              w_idu_act;
    logic              w_idu_wrap;
    logic [DATA_W-1:0] w_fmask;
    logic [DATA_W-1:0] w_bank [8];

    // Flag enables line up with the top four bits of F: {Z,N,H,C}
    assign w_fmask = {flags_mask, {(DATA_W-4){1'b0}}};

    always_comb begin
        w_idu_old = '0;
        w_idu_act = 1'b0;
        case (idu_sel)
            c_T_PC: begin w_idu_old = r_pc;       w_idu_act = idu_en; end
            c_T_BC: begin w_idu_old = {r_b, r_c}; w_idu_act = idu_en; end
            c_T_DE: begin w_idu_old = {r_d, r_e}; w_idu_act = idu_en; end
            c_T_HL: begin w_idu_old = {r_h, r_l}; w_idu_act = idu_en; end
            c_T_SP: begin w_idu_old = r_sp;       w_idu_act = idu_en; end
            default: begin w_idu_old = '0;        w_idu_act = 1'b0;   end
        endcase
    end

    assign w_idu_res  = idu_dec ? (w_idu_old - c_ONE) : (w_idu_old + c_ONE);
    assign w_idu_wrap = w_idu_act & (idu_dec ? (w_idu_old == '0) : (w_idu_old == '1));

    // Writers applied lowest priority first so later assignments win
    always_comb begin
        w_a_nx  = r_a;
        w_f_nx  = r_f;
        w_b_nx  = r_b;
        w_c_nx  = r_c;
        w_d_nx  = r_d;
        w_e_nx  = r_e;
        w_h_nx  = r_h;
        w_l_nx  = r_l;
        w_pc_nx = r_pc;
        w_sp_nx = r_sp;

        if (wr_en) begin
            case (wr_sel)
                c_SEL_B: w_b_nx = data_in;
                c_SEL_C: w_c_nx = data_in;
                c_SEL_D: w_d_nx = data_in;
                c_SEL_E: w_e_nx = data_in;
                c_SEL_H: w_h_nx = data_in;
                c_SEL_L: w_l_nx = data_in;
                c_SEL_F: w_f_nx = data_in;
                default: w_a_nx = data_in;
            endcase
        end

        if (flags_wr_en) begin
            w_f_nx = (w_f_nx & ~w_fmask) | (flags_in & w_fmask);
        end
        w_f_nx = w_f_nx & FLAG_MASK;

        if (wr16_en) begin
            case (wr16_sel)
                c_P16_BC: {w_b_nx, w_c_nx} = data16_in;
                c_P16_DE: {w_d_nx, w_e_nx} = data16_in;
                c_P16_HL: {w_h_nx, w_l_nx} = data16_in;
                default:  w_sp_nx          = data16_in;
            endcase
        end

        if (w_idu_act) begin
            case (idu_sel)
                c_T_PC:  w_pc_nx          = w_idu_res;
                c_T_BC:  {w_b_nx, w_c_nx} = w_idu_res;
                c_T_DE:  {w_d_nx, w_e_nx} = w_idu_res;
                c_T_HL:  {w_h_nx, w_l_nx} = w_idu_res;
                default: w_sp_nx          = w_idu_res;
            endcase
        end

        if (pc_load) begin
            w_pc_nx = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a        <= '0;
            r_f        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_e        <= '0;
            r_h        <= '0;
            r_l        <= '0;
            r_pc       <= PC_RESET;
            r_sp       <= SP_RESET;
            r_idu_wrap <= 1'b0;
        end else begin
            r_a        <= w_a_nx;
            r_f        <= w_f_nx;
            r_b        <= w_b_nx;
            r_c        <= w_c_nx;
            r_d        <= w_d_nx;
            r_e        <= w_e_nx;
            r_h        <= w_h_nx;
            r_l        <= w_l_nx;
            r_pc       <= w_pc_nx;
            r_sp       <= w_sp_nx;
            r_idu_wrap <= w_idu_wrap;
        end
    end

    always_comb begin
        w_bank[c_SEL_B] = r_b;
        w_bank[c_SEL_C] = r_c;
        w_bank[c_SEL_D] = r_d;
        w_bank[c_SEL_E] = r_e;
        w_bank[c_SEL_H] = r_h;
        w_bank[c_SEL_L] = r_l;
        w_bank[c_SEL_F] = r_f & FLAG_MASK;
        w_bank[c_SEL_A] = r_a;
    end

    assign data_out_a = w_bank[rd_sel_a];
    assign data_out_b = w_bank[rd_sel_b];

    // Bus always carries pre-update register values
    always_comb begin
        case (addr_sel)
            c_T_PC:  addr_bus = r_pc;
            c_T_BC:  addr_bus = {r_b, r_c};
            c_T_DE:  addr_bus = {r_d, r_e};
            c_T_HL:  addr_bus = {r_h, r_l};
            c_T_SP:  addr_bus = r_sp;
            c_T_HC:  addr_bus = {{DATA_W{1'b1}}, r_c};
            c_T_PI:  addr_bus = pc_in;
            default: addr_bus = data16_in;
        endcase
    end

    assign flags_out = r_f & FLAG_MASK;
    assign pc_out    = r_pc;
    assign sp_out    = r_sp;
    assign idu_wrap  = r_idu_wrap;

endmodule
`default_nettype wire

// File: tb/tb_regfile_idu.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_idu
// Description : Directed and randomized checks of regfile_idu against a
//               behavioural register-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_idu;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  data_in;
    logic        wr16_en;
    logic [1:0]  wr16_sel;
    logic [15:0] data16_in;
    logic        flags_wr_en;
    logic [7:0]  flags_in;
    logic [3:0]  flags_mask;
    logic [2:0]  rd_sel_a;
    logic [2:0]  rd_sel_b;
    logic [7:0]  data_out_a;
    logic [7:0]  data_out_b;
    logic        idu_en;
    logic [2:0]  idu_sel;
    logic        idu_dec;
    logic        pc_load;
    logic [15:0] pc_in;
    logic [2:0]  addr_sel;
    logic [15:0] addr_bus;
    logic [7:0]  flags_out;
    logic [15:0] pc_out;
    logic [15:0] sp_out;
    logic        idu_wrap;

    int errors = 0;
    int checks = 0;

    // Model: index by register select code (B C D E H L F A)
    logic [7:0]  m_r [8];
    logic [15:0] m_pc;
    logic [15:0] m_sp;
    logic        m_wrap;

    always #5 clk = ~clk;

    regfile_idu dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .data_in(data_in),
        .wr16_en(wr16_en), .wr16_sel(wr16_sel), .data16_in(data16_in),
        .flags_wr_en(flags_wr_en), .flags_in(flags_in), .flags_mask(flags_mask),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec),
        .pc_load(pc_load), .pc_in(pc_in),
        .addr_sel(addr_sel), .addr_bus(addr_bus),
        .flags_out(flags_out), .pc_out(pc_out), .sp_out(sp_out),
        .idu_wrap(idu_wrap)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pair16(input int k);
        return {m_r[2*k], m_r[2*k+1]};
    endfunction

    function automatic logic [15:0] exp_addr(input logic [2:0] s);
        case (s)
            3'd0:    return m_pc;
            3'd1:    return pair16(0);
            3'd2:    return pair16(1);
            3'd3:    return pair16(2);
            3'd4:    return m_sp;
            3'd5:    return {8'hFF, m_r[1]};
            3'd6:    return pc_in;
            default: return data16_in;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_pc   = 16'h0000;
        m_sp   = 16'hFFFE;
        m_wrap = 1'b0;
    endtask

    task automatic clr();
        rst = 1'b1; wr_en = 0; wr_sel = 0; data_in = 0;
        wr16_en = 0; wr16_sel = 0; data16_in = 0;
        flags_wr_en = 0; flags_in = 0; flags_mask = 0;
        rd_sel_a = 0; rd_sel_b = 0; idu_en = 0; idu_sel = 0; idu_dec = 0;
        pc_load = 0; pc_in = 0; addr_sel = 0;
    endtask

    // Check all outputs against the model, then advance one clock
    task automatic cycle();
        logic [7:0]  nr [8];
        logic [15:0] npc, nsp;
        logic        nw;
        int          old, nv;
        #1;
        chk("rd_a",  {8'h00, data_out_a}, {8'h00, m_r[rd_sel_a]});
        chk("rd_b",  {8'h00, data_out_b}, {8'h00, m_r[rd_sel_b]});
        chk("addr",  addr_bus, exp_addr(addr_sel));
        chk("flags", {8'h00, flags_out}, {8'h00, m_r[6]});
        chk("pc",    pc_out, m_pc);
        chk("sp",    sp_out, m_sp);
        chk("wrap",  {15'h0, idu_wrap}, {15'h0, m_wrap});

        nr = m_r; npc = m_pc; nsp = m_sp; nw = 1'b0;
        if (wr_en) nr[wr_sel] = (wr_sel == 3'd6) ? (data_in & 8'hF0) : data_in;
        if (flags_wr_en)
            for (int k = 0; k < 4; k++)
                if (flags_mask[k]) nr[6][4+k] = flags_in[4+k];
        if (wr16_en) begin
            if (wr16_sel == 2'd3) nsp = data16_in;
            else begin
                nr[2*wr16_sel]   = data16_in[15:8];
                nr[2*wr16_sel+1] = data16_in[7:0];
            end
        end
        if (idu_en && idu_sel <= 3'd4) begin
            if (idu_sel == 3'd0)      old = int'(m_pc);
            else if (idu_sel == 3'd4) old = int'(m_sp);
            else                      old = int'(pair16(int'(idu_sel) - 1));
            nv = idu_dec ? (old + 65535) % 65536 : (old + 1) % 65536;
            nw = idu_dec ? (old == 0) : (old == 65535);
            if (idu_sel == 3'd0)      npc = 16'(nv);
            else if (idu_sel == 3'd4) nsp = 16'(nv);
            else begin
                nr[2*(idu_sel-1)]   = 8'(nv >> 8);
                nr[2*(idu_sel-1)+1] = 8'(nv);
            end
        end
        if (pc_load) npc = pc_in;

        @(posedge clk);
        if (!rst) model_reset();
        else begin
            m_r = nr; m_pc = npc; m_sp = nsp; m_wrap = nw;
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        clr();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        cycle();

        // Reset state
        clr(); rd_sel_a = 3'd7; rd_sel_b = 3'd4; #1;
        chk("rst_pc",    pc_out, 16'h0000);
        chk("rst_sp",    sp_out, 16'hFFFE);
        chk("rst_a",     {8'h00, data_out_a}, 16'h0000);
        chk("rst_h",     {8'h00, data_out_b}, 16'h0000);
        chk("rst_flags", {8'h00, flags_out}, 16'h0000);
        chk("rst_wrap",  {15'h0, idu_wrap}, 16'h0000);

        // A=3C, HL=C000
        clr(); wr_en = 1; wr_sel = 3'd7; data_in = 8'h3C;
        wr16_en = 1; wr16_sel = 2'd2; data16_in = 16'hC000;
        cycle();
        clr(); rd_sel_a = 3'd7; addr_sel = 3'd3; #1;
        chk("a_3c",    {8'h00, data_out_a}, 16'h003C);
        chk("hl_c000", addr_bus, 16'hC000);

        // HL+ shows old HL on the bus
        clr(); idu_en = 1; idu_sel = 3'd3; addr_sel = 3'd3; #1;
        chk("hl_inc_bus", addr_bus, 16'hC000);
        cycle();
        clr(); addr_sel = 3'd3; #1;
        chk("hl_inc_after", addr_bus, 16'hC001);

        // SP 0000 - 1 wraps
        clr(); wr16_en = 1; wr16_sel = 2'd3; data16_in = 16'h0000; cycle();
        clr(); idu_en = 1; idu_sel = 3'd4; idu_dec = 1; cycle();
        clr(); #1;
        chk("sp_wrap_val", sp_out, 16'hFFFF);
        chk("sp_wrap_flag", {15'h0, idu_wrap}, 16'h0001);
        cycle();
        clr(); #1;
        chk("sp_wrap_clear", {15'h0, idu_wrap}, 16'h0000);

        // Flag merge and masked POP AF
        clr(); wr_en = 1; wr_sel = 3'd6; data_in = 8'hF0; cycle();
        clr(); flags_wr_en = 1; flags_in = 8'h00; flags_mask = 4'b1000; cycle();
        clr(); #1;
        chk("flag_merge", {8'h00, flags_out}, 16'h0070);
        clr(); wr_en = 1; wr_sel = 3'd6; data_in = 8'hFF; cycle();
        clr(); #1;
        chk("flag_pop", {8'h00, flags_out}, 16'h00F0);

        // pc_load beats PC increment
        clr(); pc_load = 1; pc_in = 16'h0038; idu_en = 1; idu_sel = 3'd0; cycle();
        clr(); #1;
        chk("pc_load", pc_out, 16'h0038);

        // IDU on HL beats wr8 to L
        clr(); idu_en = 1; idu_sel = 3'd3; wr_en = 1; wr_sel = 3'd5; data_in = 8'h55; cycle();
        clr(); addr_sel = 3'd3; #1;
        chk("hl_idu_vs_l", addr_bus, 16'hC002);

        // Reserved IDU target
        clr(); idu_en = 1; idu_sel = 3'd5; cycle();
        clr(); #1;
        chk("idu_rsv_pc", pc_out, 16'h0038);
        chk("idu_rsv_wrap", {15'h0, idu_wrap}, 16'h0000);

        // Reset mid-operation
        clr(); rst = 0; wr_en = 1; wr_sel = 3'd7; data_in = 8'hAA; idu_en = 1; pc_load = 1; pc_in = 16'h1234;
        cycle();
        clr(); rd_sel_a = 3'd7; addr_sel = 3'd3; #1;
        chk("mid_rst_a",  {8'h00, data_out_a}, 16'h0000);
        chk("mid_rst_pc", pc_out, 16'h0000);
        chk("mid_rst_sp", sp_out, 16'hFFFE);
        chk("mid_rst_hl", addr_bus, 16'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 49) != 0);
            wr_en       = 1'($urandom_range(0, 1));
            wr_sel      = 3'($urandom_range(0, 7));
            data_in     = 8'($urandom);
            wr16_en     = ($urandom_range(0, 3) == 0);
            wr16_sel    = 2'($urandom_range(0, 3));
            r           = int'($urandom_range(0, 3));
            data16_in   = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            flags_wr_en = 1'($urandom_range(0, 1));
            flags_in    = 8'($urandom);
            flags_mask  = 4'($urandom);
            rd_sel_a    = 3'($urandom_range(0, 7));
            rd_sel_b    = 3'($urandom_range(0, 7));
            idu_en      = 1'($urandom_range(0, 1));
            idu_sel     = 3'($urandom_range(0, 7));
            idu_dec     = 1'($urandom_range(0, 1));
            pc_load     = ($urandom_range(0, 7) == 0);
            r           = int'($urandom_range(0, 3));
            pc_in       = (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
            addr_sel    = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
